// File: rtl/predecode_queue_pkg.sv
// predecode_queue_pkg
//   Shared definitions for the pre-decode queue: RV opcode constants,
//   the instruction-format code, the decoded-field record stored per FIFO
//   entry, and the opcode -> format lookup used by the field extractor.
package predecode_queue_pkg;

  localparam int DATA_WIDTH_DEF = 32;

  localparam logic [6:0] OP_OP       = 7'b0110011;
  localparam logic [6:0] OP_OP32     = 7'b0111011;
  localparam logic [6:0] OP_IMM      = 7'b0010011;
  localparam logic [6:0] OP_IMM32    = 7'b0011011;
  localparam logic [6:0] OP_LOAD     = 7'b0000011;
  localparam logic [6:0] OP_JALR     = 7'b1100111;
  localparam logic [6:0] OP_SYSTEM   = 7'b1110011;
  localparam logic [6:0] OP_MISC_MEM = 7'b0001111;
  localparam logic [6:0] OP_STORE    = 7'b0100011;
  localparam logic [6:0] OP_BRANCH   = 7'b1100011;
  localparam logic [6:0] OP_LUI      = 7'b0110111;
  localparam logic [6:0] OP_AUIPC    = 7'b0010111;
  localparam logic [6:0] OP_JAL      = 7'b1101111;

  typedef enum logic [2:0] {
    FMT_R   = 3'd0,
    FMT_I   = 3'd1,
    FMT_S   = 3'd2,
    FMT_B   = 3'd3,
    FMT_U   = 3'd4,
    FMT_J   = 3'd5,
    FMT_UNK = 3'd7
  } fmt_e;

  // Everything decoded from the 32 instruction bits except the immediate,
  // whose width follows DATA_WIDTH and is therefore kept separately.
  typedef struct packed {
    logic [6:0]  op;
    logic [4:0]  rd;
    logic [2:0]  func3;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [6:0]  func7;
    logic [11:0] csr;
    fmt_e        fmt;
    logic        illegal;
  } fields_t;

  function automatic fmt_e fmt_of(input logic [6:0] op);
    fmt_e f;
    case (op)
      OP_OP, OP_OP32:                            f = FMT_R;
      OP_IMM, OP_IMM32, OP_LOAD, OP_JALR,
      OP_SYSTEM, OP_MISC_MEM:                    f = FMT_I;
      OP_STORE:                                  f = FMT_S;
      OP_BRANCH:                                 f = FMT_B;
      OP_LUI, OP_AUIPC:                          f = FMT_U;
      OP_JAL:                                    f = FMT_J;
      default:                                   f = FMT_UNK;
    endcase
    return f;
  endfunction

endpackage

// File: rtl/predecode_fields.sv
// predecode_fields
//   Purely combinational field extractor for one 32-bit instruction.
//   Ports:
//     i_instr  - raw instruction
//     o_fields - register/function/CSR fields, format code, illegal flag
//     o_imm    - immediate for the decoded format, sign-extended from
//                instr[31] to DATA_WIDTH (zero for R and unknown formats)
module predecode_fields
  import predecode_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF
) (
  input  logic [31:0]           i_instr,
  output fields_t               o_fields,
  output logic [DATA_WIDTH-1:0] o_imm
);

  fmt_e        w_fmt;
  logic [31:0] w_imm32;

  always_comb begin
    w_fmt = fmt_of(i_instr[6:0]);

    o_fields.op      = i_instr[6:0];
    o_fields.rd      = i_instr[11:7];
    o_fields.func3   = i_instr[14:12];
    o_fields.rs1     = i_instr[19:15];
    o_fields.rs2     = i_instr[24:20];
    o_fields.func7   = i_instr[31:25];
    o_fields.csr     = i_instr[31:20];
    o_fields.fmt     = w_fmt;
    o_fields.illegal = (i_instr[1:0] != 2'b11) || (w_fmt == FMT_UNK);

    // Build a 32-bit sign-extended immediate first; widening to 64 bits
    // below only replicates bit 31.
    case (w_fmt)
      FMT_I:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:20]};
      FMT_S:   w_imm32 = {{20{i_instr[31]}}, i_instr[31:25], i_instr[11:7]};
      FMT_B:   w_imm32 = {{19{i_instr[31]}}, i_instr[31], i_instr[7],
                          i_instr[30:25], i_instr[11:8], 1'b0};
      FMT_U:   w_imm32 = {i_instr[31:12], 12'b0};
      FMT_J:   w_imm32 = {{11{i_instr[31]}}, i_instr[31], i_instr[19:12],
                          i_instr[20], i_instr[30:21], 1'b0};
      default: w_imm32 = 32'b0;
    endcase

    o_imm = DATA_WIDTH'($signed(w_imm32));
  end

endmodule

// File: rtl/predecode_queue.sv
// predecode_queue
//   Pre-decode stage between fetch and decode. Instructions are decoded on
//   the way in and the results are held in a DEPTH-entry FIFO so that both
//   sides can stall independently. A flush empties the queue in one edge.
//
//   Handshakes: a transfer happens at a rising edge where valid && ready are
//   both high on that interface. in_ready depends only on occupancy (and is
//   forced high by flush); out_valid depends only on occupancy. Neither ready
//   nor valid combinationally depends on the partner's valid/ready.
//
//   Ports:
//     clk, rst_n            - clock, asynchronous active-low reset
//     in_valid/in_ready     - enqueue handshake; in_instr, in_pc payload
//     flush                 - discard every entry (redirect / trap)
//     out_valid/out_ready   - dequeue handshake for the head entry
//     out_pc .. out_csr     - head PC and raw instruction fields
//     out_imm, out_fmt      - head immediate and format code
//     out_illegal           - head instruction is not a known 32-bit opcode
//     count                 - number of occupied entries
module predecode_queue
  import predecode_queue_pkg::*;
#(
  parameter int DATA_WIDTH = DATA_WIDTH_DEF,
  parameter int ADDR_WIDTH = 32,
  parameter int DEPTH      = 4
) (
  input  logic                      clk,
  input  logic                      rst_n,
  input  logic                      in_valid,
  output logic                      in_ready,
  input  logic [31:0]               in_instr,
  input  logic [ADDR_WIDTH-1:0]     in_pc,
  input  logic                      flush,
  output logic                      out_valid,
  input  logic                      out_ready,
  output logic [ADDR_WIDTH-1:0]     out_pc,
  output logic [6:0]                out_op,
  output logic [4:0]                out_rd,
  output logic [2:0]                out_func3,
  output logic [4:0]                out_rs1,
  output logic [4:0]                out_rs2,
  output logic [6:0]                out_func7,
  output logic [11:0]               out_csr,
  output logic [DATA_WIDTH-1:0]     out_imm,
  output logic [2:0]                out_fmt,
  output logic                      out_illegal,
  output logic [$clog2(DEPTH):0]    count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;

  // Decoder on the enqueue side
  fields_t               w_in_fields;
  logic [DATA_WIDTH-1:0] w_in_imm;

  predecode_fields #(
    .DATA_WIDTH (DATA_WIDTH)
  ) u_fields (
    .i_instr  (in_instr),
    .o_fields (w_in_fields),
    .o_imm    (w_in_imm)
  );

  // Entry storage (not reset; contents are meaningless until written)
  fields_t               r_fields [DEPTH];
  logic [DATA_WIDTH-1:0] r_imm    [DEPTH];
  logic [ADDR_WIDTH-1:0] r_pc     [DEPTH];

  logic [PW-1:0] r_wr_ptr;
  logic [PW-1:0] r_rd_ptr;
  logic [CW-1:0] r_count;

  logic    w_full;
  logic    w_enq;
  logic    w_deq;
  fields_t w_head;

  // Full is judged on the pre-edge count, so a full queue refuses an
  // enqueue even when the head is leaving in the same cycle.
  assign w_full    = (r_count == CW'(DEPTH));
  assign in_ready  = flush | ~w_full;
  assign out_valid = (r_count != '0);

  // Flush wins over both handshakes.
  assign w_enq = in_valid & ~w_full & ~flush;
  assign w_deq = out_valid & out_ready & ~flush;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else if (flush) begin
      r_wr_ptr <= '0;
      r_rd_ptr <= '0;
      r_count  <= '0;
    end else begin
      // DEPTH is a power of two, so the pointers wrap by overflow.
      if (w_enq) r_wr_ptr <= r_wr_ptr + PW'(1);
      if (w_deq) r_rd_ptr <= r_rd_ptr + PW'(1);
      case ({w_enq, w_deq})
        2'b10:   r_count <= r_count + CW'(1);
        2'b01:   r_count <= r_count - CW'(1);
        default: r_count <= r_count;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (w_enq) begin
      r_fields[r_wr_ptr] <= w_in_fields;
      r_imm[r_wr_ptr]    <= w_in_imm;
      r_pc[r_wr_ptr]     <= in_pc;
    end
  end

  assign w_head      = r_fields[r_rd_ptr];
  assign out_pc      = r_pc[r_rd_ptr];
  assign out_imm     = r_imm[r_rd_ptr];
  assign out_op      = w_head.op;
  assign out_rd      = w_head.rd;
  assign out_func3   = w_head.func3;
  assign out_rs1     = w_head.rs1;
  assign out_rs2     = w_head.rs2;
  assign out_func7   = w_head.func7;
  assign out_csr     = w_head.csr;
  assign out_fmt     = w_head.fmt;
  assign out_illegal = w_head.illegal;
  assign count       = r_count;

endmodule

// File: tb/tb_predecode_queue.sv
module tb_predecode_queue;

  localparam int DW    = 32;
  localparam int AW    = 32;
  localparam int DEPTH = 4;

  // ---------------- clock / reset ----------------
  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  logic          in_valid, in_ready, flush, out_valid, out_ready;
  logic [31:0]   in_instr;
  logic [AW-1:0] in_pc, out_pc;
  logic [6:0]    out_op, out_func7;
  logic [4:0]    out_rd, out_rs1, out_rs2;
  logic [2:0]    out_func3, out_fmt;
  logic [11:0]   out_csr;
  logic [DW-1:0] out_imm;
  logic          out_illegal;
  logic [2:0]    count;

  predecode_queue #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .DEPTH(DEPTH)) dut (
    .clk(clk), .rst_n(rst_n),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_op(out_op), .out_rd(out_rd), .out_func3(out_func3), .out_rs1(out_rs1),
    .out_rs2(out_rs2), .out_func7(out_func7), .out_csr(out_csr),
    .out_imm(out_imm), .out_fmt(out_fmt), .out_illegal(out_illegal),
    .count(count)
  );

  // ---------------- scoreboard ----------------
  // Each queued item is {pc, instr}; the model is just an ordered queue.
  logic [63:0] exp_q[$];
  int n_pass  = 0;
  int n_total = 0;
  logic last_enq;
  logic chk_on = 1'b0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_total++;
    if (act !== exp)
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    else
      n_pass++;
  endtask

  // Reference decode written straight from the format/immediate rules.
  function automatic void ref_dec(input logic [31:0] ins, output logic [2:0] fmt,
                                  output logic [31:0] imm, output logic ill);
    logic [11:0] i12;
    logic [11:0] s12;
    logic [12:0] b13;
    logic [20:0] j21;
    i12 = ins[31:20];
    s12 = {ins[31:25], ins[11:7]};
    b13 = {ins[31], ins[7], ins[30:25], ins[11:8], 1'b0};
    j21 = {ins[31], ins[19:12], ins[20], ins[30:21], 1'b0};
    case (ins[6:0])
      7'h33, 7'h3B:                             fmt = 3'd0;
      7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F: fmt = 3'd1;
      7'h23:                                    fmt = 3'd2;
      7'h63:                                    fmt = 3'd3;
      7'h37, 7'h17:                             fmt = 3'd4;
      7'h6F:                                    fmt = 3'd5;
      default:                                  fmt = 3'd7;
    endcase
    case (fmt)
      3'd1:    imm = 32'($signed(i12));
      3'd2:    imm = 32'($signed(s12));
      3'd3:    imm = 32'($signed(b13));
      3'd4:    imm = {ins[31:12], 12'h000};
      3'd5:    imm = 32'($signed(j21));
      default: imm = 32'h0;
    endcase
    ill = (fmt == 3'd7);
  endfunction

  // Compare process: every cycle, away from the active edge.
  always @(negedge clk) begin
    if (rst_n && chk_on) begin
      chk("in_ready", {63'b0, in_ready}, {63'b0, (flush || exp_q.size() < DEPTH)});
      chk("out_valid", {63'b0, out_valid}, {63'b0, (exp_q.size() != 0)});
      chk("count", {61'b0, count}, 64'(exp_q.size()));
      if (exp_q.size() != 0) begin
        logic [31:0] ins;
        logic [2:0]  f;
        logic [31:0] im;
        logic        il;
        ins = exp_q[0][31:0];
        ref_dec(ins, f, im, il);
        chk("pc",    {32'b0, out_pc}, {32'b0, exp_q[0][63:32]});
        chk("op",    {57'b0, out_op}, {57'b0, ins[6:0]});
        chk("rd",    {59'b0, out_rd}, {59'b0, ins[11:7]});
        chk("func3", {61'b0, out_func3}, {61'b0, ins[14:12]});
        chk("rs1",   {59'b0, out_rs1}, {59'b0, ins[19:15]});
        chk("rs2",   {59'b0, out_rs2}, {59'b0, ins[24:20]});
        chk("func7", {57'b0, out_func7}, {57'b0, ins[31:25]});
        chk("csr",   {52'b0, out_csr}, {52'b0, ins[31:20]});
        chk("imm",   {32'b0, out_imm}, {32'b0, im});
        chk("fmt",   {61'b0, out_fmt}, {61'b0, f});
        chk("illegal", {63'b0, out_illegal}, {63'b0, il});
      end
    end
  end

  // ---------------- driver tasks ----------------
  // One clock: the model consumes the inputs seen at the edge.
  task automatic step();
    @(posedge clk);
    last_enq = 1'b0;
    if (rst_n) begin
      if (flush) begin
        exp_q.delete();
      end else begin
        logic full;
        full = (exp_q.size() == DEPTH);
        if (exp_q.size() != 0 && out_ready) void'(exp_q.pop_front());
        if (in_valid && !full) begin
          exp_q.push_back({in_pc, in_instr});
          last_enq = 1'b1;
        end
      end
    end
    #1;
  endtask

  task automatic drive(input logic v, input logic [31:0] ins, input logic [31:0] pc,
                       input logic rdy, input logic fl);
    in_valid  = v;
    in_instr  = ins;
    in_pc     = pc;
    out_ready = rdy;
    flush     = fl;
  endtask

  task automatic idle();
    drive(1'b0, 32'h0, 32'h0, 1'b0, 1'b0);
  endtask

  function automatic logic [31:0] rand_instr();
    logic [6:0] ops [13];
    logic [31:0] r;
    ops = '{7'h33, 7'h3B, 7'h13, 7'h1B, 7'h03, 7'h67, 7'h73, 7'h0F,
            7'h23, 7'h63, 7'h37, 7'h17, 7'h6F};
    r = $urandom;
    if ($urandom_range(0, 7) != 0) r[6:0] = ops[$urandom_range(0, 12)];
    return r;
  endfunction

  // ---------------- stimulus ----------------
  initial begin
    rst_n = 1'b0;
    idle();
    repeat (2) @(posedge clk);
    #1 rst_n = 1'b1;
    #1;
    // reset state
    chk("rst_out_valid", {63'b0, out_valid}, 64'd0);
    chk("rst_in_ready",  {63'b0, in_ready},  64'd1);
    chk("rst_count",     {61'b0, count},     64'd0);
    chk_on = 1'b1;

    // addi x1,x0,-1
    drive(1'b1, 32'hFFF00093, 32'h80000000, 1'b1, 1'b0);
    step();
    idle(); out_ready = 1'b1;
    chk("addi_valid", {63'b0, out_valid}, 64'd1);
    chk("addi_op",    {57'b0, out_op},    64'h13);
    chk("addi_rd",    {59'b0, out_rd},    64'd1);
    chk("addi_rs1",   {59'b0, out_rs1},   64'd0);
    chk("addi_fmt",   {61'b0, out_fmt},   64'd1);
    chk("addi_imm",   {32'b0, out_imm},   64'hFFFFFFFF);
    chk("addi_pc",    {32'b0, out_pc},    64'h80000000);
    step();
    chk("addi_gone",  {63'b0, out_valid}, 64'd0);

    // beq, lui, and two illegal encodings: enqueue, inspect head, drain
    drive(1'b1, 32'hFE000EE3, 32'h100, 1'b0, 1'b0); step();
    drive(1'b1, 32'h123452B7, 32'h104, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00000000, 32'h108, 1'b0, 1'b0); step();
    drive(1'b1, 32'h0000007F, 32'h10C, 1'b0, 1'b0); step();
    idle();
    chk("beq_fmt", {61'b0, out_fmt}, 64'd3);
    chk("beq_imm", {32'b0, out_imm}, 64'hFFFFFFFC);
    out_ready = 1'b1; step();
    chk("lui_fmt", {61'b0, out_fmt}, 64'd4);
    chk("lui_rd",  {59'b0, out_rd},  64'd5);
    chk("lui_imm", {32'b0, out_imm}, 64'h12345000);
    step();
    chk("zero_ill", {63'b0, out_illegal}, 64'd1);
    chk("zero_fmt", {61'b0, out_fmt},     64'd7);
    chk("zero_imm", {32'b0, out_imm},     64'd0);
    step();
    chk("7f_ill", {63'b0, out_illegal}, 64'd1);
    chk("7f_fmt", {61'b0, out_fmt},     64'd7);
    chk("7f_imm", {32'b0, out_imm},     64'd0);
    step();
    chk("drained", {61'b0, count}, 64'd0);

    // fill to full with 5 offered, then drain through the wrap
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 32'h00100013 + (i << 7), 32'h200 + 4 * i, 1'b0, 1'b0);
      step();
    end
    chk("full_count", {61'b0, count},    64'd4);
    chk("full_ready", {63'b0, in_ready}, 64'd0);
    out_ready = 1'b1;
    for (int k = 0; k < 10 && !last_enq; k++) step();
    chk("fifth_accepted", {63'b0, last_enq}, 64'd1);
    in_valid = 1'b0;
    repeat (6) step();
    chk("wrap_empty", {61'b0, count}, 64'd0);

    // flush with coincident enqueue and dequeue
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 32'h00A00513 + i, 32'h300 + 4 * i, 1'b0, 1'b0);
      step();
    end
    drive(1'b1, 32'h00B00593, 32'h3F0, 1'b1, 1'b1);
    step();
    idle();
    chk("flush_count", {61'b0, count},     64'd0);
    chk("flush_valid", {63'b0, out_valid}, 64'd0);
    repeat (2) step();
    chk("flush_dropped", {63'b0, out_valid}, 64'd0);

    // asynchronous reset mid-cycle with two entries queued
    drive(1'b1, 32'h00C00613, 32'h400, 1'b0, 1'b0); step();
    drive(1'b1, 32'h00D00693, 32'h404, 1'b0, 1'b0); step();
    idle();
    #2 rst_n = 1'b0;
    #1;
    chk("arst_valid", {63'b0, out_valid}, 64'd0);
    chk("arst_count", {61'b0, count},     64'd0);
    exp_q.delete();
    @(posedge clk);
    #1 rst_n = 1'b1;
    drive(1'b1, 32'hFFF00093, 32'h80000040, 1'b0, 1'b0);
    step();
    idle();
    chk("post_rst_pc",  {32'b0, out_pc},  64'h80000040);
    chk("post_rst_imm", {32'b0, out_imm}, 64'hFFFFFFFF);
    out_ready = 1'b1;
    step();

    // randomized traffic
    for (int c = 0; c < 2000; c++) begin
      drive(1'($urandom_range(0, 1)), rand_instr(), $urandom,
            1'($urandom_range(0, 2) != 0), 1'($urandom_range(0, 40) == 0));
      step();
    end
    idle(); out_ready = 1'b1;
    repeat (6) step();
    chk("final_empty", {61'b0, count}, 64'd0);

    chk_on = 1'b0;
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/predecode_queue.md
Name: predecode_queue

Overview:
Buffered, parametrised pre-decode stage between instruction fetch and the main decoder. Accepts raw instructions plus PC over a valid/ready handshake and extracts all register, function and CSR fields. It also generates the sign-extended immediate and an instruction-format code at enqueue time. Results are stored in a DEPTH-entry FIFO so fetch and decode can stall independently, and the FIFO is flushable on redirect.

Parameters:
DATA_WIDTH, 32, instruction/immediate width (32 or 64; instruction bits always [31:0])
ADDR_WIDTH, 32, PC width
DEPTH, 4, FIFO entries; power of two, >= 2

Ports:
clk  in  1  clock
rst_n  in  1  asynchronous active-low reset
in_valid  in  1  fetch presents an instruction
in_ready  out  1  queue can accept
in_instr  in  32  raw instruction
in_pc  in  ADDR_WIDTH  PC of in_instr
flush  in  1  discard all entries (branch redirect / trap)
out_valid  out  1  head entry valid
out_ready  in  1  decoder consumes head
out_pc  out  ADDR_WIDTH  head PC
out_op  out  7  instr[6:0]
out_rd  out  5  instr[11:7]
out_func3  out  3  instr[14:12]
out_rs1  out  5  instr[19:15]
out_rs2  out  5  instr[24:20]
out_func7  out  7  instr[31:25]
out_csr  out  12  instr[31:20]
out_imm  out  DATA_WIDTH  sign-extended immediate per format
out_fmt  out  3  0=R 1=I 2=S 3=B 4=U 5=J 7=unknown
out_illegal  out  1  instr[1:0]!=2'b11 or unknown opcode
count  out  $clog2(DEPTH)+1  occupied entries

Behaviour:
- Reset (async, rst_n=0): read/write pointers and count cleared. out_valid=0, in_ready=1. Entry storage is not reset; out_* data outputs are don't-care while out_valid=0.
- Enqueue: fires on in_valid && in_ready at a rising edge. Fields are decoded combinationally from in_instr and written into the FIFO with in_pc.
- Dequeue: fires on out_valid && out_ready.
- Latency: an instruction enqueued into an empty queue at edge N is visible on out_* from edge N (out_valid=1 in cycle N+1). There is no same-cycle bypass.
- in_ready = (count < DEPTH). No enqueue while full, even if a dequeue occurs in the same cycle.
- out_valid = (count != 0). out_* show the head entry.
- Simultaneous enqueue and dequeue (not full, not empty): count unchanged, both pointers advance.
- Pointers wrap modulo DEPTH. count distinguishes full from empty.
- Flush has priority: at the edge with flush=1, count=0 and pointers=0. A coincident enqueue is dropped and a coincident dequeue is discarded. in_ready stays 1 during flush.
- Format map by opcode:
  - 0110011/0111011 -> R
  - 0010011/0011011/0000011/1100111/1110011/0001111 -> I
  - 0100011 -> S
  - 1100011 -> B
  - 0110111/0010111 -> U
  - 1101111 -> J
  - others -> 7, with illegal=1
- Immediates, all sign-extended from instr[31] to DATA_WIDTH:
  - I: instr[31:20]
  - S: {instr[31:25], instr[11:7]}
  - B: {instr[31], instr[7], instr[30:25], instr[11:8], 0}
  - U: {instr[31:12], 12'b0}
  - J: {instr[31], instr[19:12], instr[20], instr[30:21], 0}
  - R/unknown: 0
- Fields are extracted regardless of format. The consumer qualifies them with out_fmt.

Decomposition:
- Opcode constants, format codes and DATA_WIDTH default go in the shared define.v.
- One natural sub-module: predecode_fields. It is purely combinational: 32-bit instruction in, field/imm/fmt/illegal out, parametrised by DATA_WIDTH. It is instantiated on the enqueue side.
- The FIFO and handshake logic live in predecode_queue.

Test Plan:
- Enqueue 0xFFF00093 (addi x1,x0,-1), PC 0x80000000, out_ready=1 -> next cycle out_valid=1, op=0x13, rd=1, rs1=0, fmt=1, imm=0xFFFFFFFF, pc=0x80000000; following cycle out_valid=0.
- Enqueue 0xFE000EE3 (beq x0,x0,-4) -> fmt=3, imm=0xFFFFFFFC. Enqueue 0x123452B7 (lui x5,0x12345) -> fmt=4, rd=5, imm=0x12345000.
- DEPTH=4, out_ready=0, in_valid=1 with 5 sequential instructions -> in_ready drops after the 4th, count=4, 5th held. Then out_ready=1 -> entries 1..5 emerge in order, pointers wrap, and count returns to 0.
- With 3 entries queued, assert flush together with in_valid and out_ready -> next cycle count=0, out_valid=0, the flushed-cycle instruction never appears.
- Enqueue 0x00000000 and 0x0000007F -> both give out_illegal=1, fmt=7, imm=0.
- Drop rst_n asynchronously mid-stream with 2 entries queued -> out_valid=0 and count=0 immediately without a clock edge. After release, the first new enqueue emerges correctly.
